// File: rtl/dmem_pkg.sv
// Shared types and sizing constants for the multi-cycle data-memory responder.
package dmem_pkg;

    localparam int WORD_W    = 32;
    localparam int LAT_MAX   = 15;
    localparam int LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_t;

endpackage

// File: rtl/dmem_lat_counter.sv
// Latency down-counter: load a start value, decrement toward zero, flag zero.
module dmem_lat_counter
    import dmem_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [LAT_CNT_W-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [LAT_CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= load_val_i;
        end else if (dec_i && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero_o = (cnt == '0);

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one request at a time, answered LATENCY+1 cycles after accept.
// Optional misaligned-access detection is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [WORD_W-1:0] req_addr_i,
    input  logic [WORD_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [WORD_W-1:0] resp_rdata_o,
    output logic              busy_o,
    output logic              err_o
);

    localparam int IDX_W = $clog2(DEPTH);

    if ((LATENCY < 1) || (LATENCY > LAT_MAX)) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 1..15");
    end
    if ((1 << IDX_W) != DEPTH) begin : g_bad_depth
        $error("dmem_responder: DEPTH must be a power of two");
    end

    dmem_state_t       state;
    dmem_state_t       state_nxt;
    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_zero;
    logic              access;
    logic              req_misalign;
    logic              lat_write;
    logic              lat_misalign;
    logic [IDX_W-1:0]  lat_idx;
    logic [WORD_W-1:0] lat_wdata;
    logic [WORD_W-1:0] rdata_q;
    logic [WORD_W-1:0] mem [DEPTH];

`ifdef DMEM_ALIGN_CHECK_EN
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr_i[WORD_W-1:IDX_W+2];
    assign req_misalign     = (req_addr_i[1:0] != 2'b00);
    assign err_o            = (state == RESP) & lat_misalign;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr_i[WORD_W-1:IDX_W+2], req_addr_i[1:0]};
    assign req_misalign     = 1'b0;
    assign err_o            = 1'b0;
`endif

    dmem_lat_counter u_lat_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (cnt_load),
        .load_val_i (LAT_CNT_W'(LATENCY - 1)),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        req_ready_o  = 1'b0;
        busy_o       = 1'b0;
        resp_valid_o = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        access       = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                busy_o      = req_valid_i;
                if (req_valid_i) begin
                    cnt_load  = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                busy_o = 1'b1;
                if (cnt_zero) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured only on accept; later input changes are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lat_write    <= 1'b0;
            lat_misalign <= 1'b0;
            lat_idx      <= '0;
            lat_wdata    <= '0;
        end else if ((state == IDLE) && req_valid_i) begin
            lat_write    <= req_write_i;
            lat_misalign <= req_misalign;
            lat_idx      <= req_addr_i[IDX_W+1:2];
            lat_wdata    <= req_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (access) begin
            if (lat_misalign) begin
                rdata_q <= '0;
            end else if (lat_write) begin
                rdata_q <= lat_wdata;
            end else begin
                rdata_q <= mem[lat_idx];
            end
        end
    end

    // The array has no reset; a store only lands on the final WAIT edge.
    always_ff @(posedge clk_i) begin
        if (access && lat_write && !lat_misalign) begin
            mem[lat_idx] <= lat_wdata;
        end
    end

    assign resp_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (LATENCY=2 and LATENCY=1 instances) against a word-array model.
module tb_dmem_responder;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        v0 = 1'b0, w0 = 1'b0;
    logic [31:0] a0 = '0, d0 = '0;
    logic        rdy0, rv0, busy0, err0;
    logic [31:0] rd0;

    logic        v1 = 1'b0, w1 = 1'b0;
    logic [31:0] a1 = '0, d1 = '0;
    logic        rdy1, rv1, busy1, err1;
    logic [31:0] rd1;

    logic [31:0] mm0 [256];
    logic [31:0] mm1 [256];
    logic [31:0] exp_q [$];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v0), .req_ready_o(rdy0), .req_write_i(w0),
        .req_addr_i(a0), .req_wdata_i(d0),
        .resp_valid_o(rv0), .resp_rdata_o(rd0), .busy_o(busy0), .err_o(err0)
    );

    dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(v1), .req_ready_o(rdy1), .req_write_i(w1),
        .req_addr_i(a1), .req_wdata_i(d1),
        .resp_valid_o(rv1), .resp_rdata_o(rd1), .busy_o(busy1), .err_o(err1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One request on either instance; every cycle from accept to one cycle past the response is checked.
    task automatic txn(input bit u1, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input string tag);
        int          lat;
        int          idx;
        logic [31:0] exp_d;
        logic        exp_e;
        logic [31:0] got;
        lat   = u1 ? 1 : 2;
        idx   = int'(a[9:2]);
        got   = '0;
        exp_e = 1'b0;
        if (ALIGN && (a[1:0] != 2'b00)) begin
            exp_d = '0;
            exp_e = 1'b1;
        end else if (w) begin
            exp_d = d;
            if (u1) mm1[idx] = d; else mm0[idx] = d;
        end else begin
            exp_d = u1 ? mm1[idx] : mm0[idx];
        end
        exp_q.push_back(exp_d);

        @(negedge clk);
        if (u1) begin v1 = 1'b1; w1 = w; a1 = a; d1 = d; end
        else    begin v0 = 1'b1; w0 = w; a0 = a; d0 = d; end
        #1;
        chk({tag, ".ready_at_req"}, u1 ? rdy1 : rdy0, 1);
        chk({tag, ".busy_at_req"}, u1 ? busy1 : busy0, 1);

        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                v0 = 1'b0; v1 = 1'b0;
                a0 = $urandom; a1 = $urandom; d0 = $urandom; d1 = $urandom;
            end
            #1;
            chk({tag, ".resp_valid"}, u1 ? rv1 : rv0, (k == lat + 1) ? 1 : 0);
            chk({tag, ".busy"}, u1 ? busy1 : busy0, (k <= lat) ? 1 : 0);
            chk({tag, ".ready_busy"}, u1 ? rdy1 : rdy0, 0);
            if (k == lat + 1) begin
                got = exp_q.pop_front();
                chk({tag, ".rdata"}, u1 ? rd1 : rd0, got);
                chk({tag, ".err"}, u1 ? err1 : err0, exp_e);
            end
        end

        @(negedge clk);
        #1;
        chk({tag, ".resp_valid_after"}, u1 ? rv1 : rv0, 0);
        chk({tag, ".ready_after"}, u1 ? rdy1 : rdy0, 1);
        chk({tag, ".rdata_held"}, u1 ? rd1 : rd0, got);
        chk({tag, ".err_after"}, u1 ? err1 : err0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset raised between clock edges must act immediately.
        #2 rst = 1'b1;
        #1;
        chk("reset.resp_valid", rv0, 0);
        chk("reset.rdata", rd0, 0);
        chk("reset.err", err0, 0);
        chk("reset.ready", rdy0, 1);
        chk("reset.busy", busy0, 0);
        chk("reset.l1_ready", rdy1, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 256; i++) begin
            txn(0, 1, 32'(i * 4), $urandom, "fill");
        end

        txn(0, 1, 32'h10, 32'hDEADBEEF, "store_10");
        txn(0, 0, 32'h10, 32'h0, "load_10");

        // Back-to-back loads with valid held high: accepts at 0 and 4, responses at 3 and 7.
        @(negedge clk);
        v0 = 1'b1; w0 = 1'b0; a0 = 32'h20;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 1) a0 = 32'h24;
            if (c == 5) v0 = 1'b0;
            #1;
            chk("b2b.resp_valid", rv0, ((c == 3) || (c == 7)) ? 1 : 0);
            chk("b2b.ready", rdy0, ((c == 0) || (c == 4)) ? 1 : 0);
            chk("b2b.busy", busy0, ((c == 3) || (c == 7)) ? 0 : 1);
            if (c == 3) chk("b2b.rdata0", rd0, mm0[8]);
            if (c == 7) chk("b2b.rdata1", rd0, mm0[9]);
        end

        txn(0, 1, 32'h400, 32'h12345678, "wrap_store");
        txn(0, 0, 32'h000, 32'h0, "wrap_load");
        txn(1, 1, 32'h400, 32'h12345678, "l1_wrap_store");
        txn(1, 0, 32'h000, 32'h0, "l1_wrap_load");

        // Store aborted by reset while still waiting must never reach the array.
        txn(0, 1, 32'h0, 32'hAAAA0000, "preload");
        @(negedge clk);
        v0 = 1'b1; w0 = 1'b1; a0 = 32'h0; d0 = 32'h5555;
        @(negedge clk);
        v0 = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort.resp_valid", rv0, 0);
        chk("abort.ready", rdy0, 1);
        chk("abort.rdata", rd0, 0);
        chk("abort.busy", busy0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            chk("abort.no_resp", rv0, 0);
        end
        txn(0, 0, 32'h0, 32'h0, "abort_load");

        txn(0, 1, 32'h13, 32'hCAFEF00D, "misalign_store");
        txn(0, 0, 32'h10, 32'h0, "misalign_check");

        for (int i = 0; i < 40; i++) begin
            txn(0, 1'($urandom_range(0, 1)), $urandom, $urandom, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
